// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
// Sequential packed-BCD to unsigned binary converter. A DIGITS-digit BCD word
// is latched on an accepted start and folded in one digit per clock, most
// significant digit first, using acc = acc*10 + digit. The result appears on S
// together with a one-cycle done pulse. Invalid nibbles (>9) are treated as 0
// and flagged; values above 2^OUT_WIDTH-1 saturate S and are flagged.
//
// Ports:
//   clk        system clock, all state changes on its rising edge
//   reset      synchronous active-low reset, highest priority
//   start      conversion request, accepted only while busy=0
//   bcd_in     packed BCD word, most significant digit in the top nibble
//   busy       high while a conversion is in progress
//   done       one-cycle pulse, S and flags valid
//   S          binary result, held until the next completed conversion
//   err_digit  sticky: a nibble of the latched word was greater than 9
//   err_ovf    sticky: the decimal value exceeded 2^OUT_WIDTH-1, S saturated
// ---------------------------------------------------------------------------
module bcd_to_bin #(
    parameter int DIGITS    = 5,
    parameter int OUT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     bcd_in,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_WIDTH-1:0]    S,
    output logic                    err_digit,
    output logic                    err_ovf
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [OUT_WIDTH-1:0] ACC_MAX  = {OUT_WIDTH{1'b1}};
    localparam logic [OUT_WIDTH+3:0] EXT_MAX  = {4'b0000, {OUT_WIDTH{1'b1}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // acc*10 + d at OUT_WIDTH+4 bits; acc < 2^OUT_WIDTH so this never wraps
    function automatic logic [OUT_WIDTH+3:0] mul10_add(
        input logic [OUT_WIDTH-1:0] a,
        input logic [3:0]           d
    );
        logic [OUT_WIDTH+3:0] ext;
        ext = {4'b0000, a};
        return (ext << 3) + (ext << 1) + {{OUT_WIDTH{1'b0}}, d};
    endfunction

    state_t                 state_r;
    logic [4*DIGITS-1:0]    sreg_r;
    logic [OUT_WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]       cnt_r;

    logic [3:0]             digit_s;
    logic                   digit_bad_s;
    logic [3:0]             digit_use_s;
    logic [OUT_WIDTH+3:0]   next_s;
    logic                   ovf_s;
    logic [OUT_WIDTH-1:0]   acc_next_s;
    logic                   last_s;

    // Digit datapath: validate the top nibble and compute the saturated next accumulator
    always_comb begin
        digit_s     = sreg_r[4*DIGITS-1 -: 4];
        digit_bad_s = 1'b0;
        digit_use_s = digit_s;
        if (digit_s > 4'd9) begin
            digit_bad_s = 1'b1;
            digit_use_s = 4'd0;
        end else begin
            digit_bad_s = 1'b0;
            digit_use_s = digit_s;
        end
        next_s = mul10_add(acc_r, digit_use_s);
        ovf_s  = 1'b0;
        if (next_s > EXT_MAX) begin
            // once clamped, acc*10 always exceeds the limit again, so it stays saturated
            ovf_s      = 1'b1;
            acc_next_s = ACC_MAX;
        end else begin
            ovf_s      = 1'b0;
            acc_next_s = next_s[OUT_WIDTH-1:0];
        end
        last_s = (cnt_r == LAST_CNT);
    end

    // Control FSM and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            sreg_r    <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            S         <= '0;
            err_digit <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sreg_r    <= bcd_in;
                        acc_r     <= '0;
                        cnt_r     <= '0;
                        err_digit <= 1'b0;
                        err_ovf   <= 1'b0;
                        busy      <= 1'b1;
                        state_r   <= CONV;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONV: begin
                    acc_r  <= acc_next_s;
                    sreg_r <= sreg_r << 4;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (digit_bad_s) begin
                        err_digit <= 1'b1;
                    end
                    if (ovf_s) begin
                        err_ovf <= 1'b1;
                    end
                    if (last_s) begin
                        S       <= acc_next_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        done    <= 1'b0;
                        state_r <= CONV;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
// Directed scoreboard bench for bcd_to_bin. The driver pushes the expected
// result (value, flags, completion cycle) when it issues a start; a monitor
// pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;

    localparam int DIGITS    = 5;
    localparam int OUT_WIDTH = 16;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [OUT_WIDTH-1:0]  S;
    logic                  err_digit;
    logic                  err_ovf;

    bcd_to_bin #(.DIGITS(DIGITS), .OUT_WIDTH(OUT_WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .S         (S),
        .err_digit (err_digit),
        .err_ovf   (err_ovf)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        ed;
        logic        eo;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cyc   = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 32'd1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk(1'b0, "unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk(S == e.s, "S", {16'd0, S}, {16'd0, e.s});
                chk(err_digit == e.ed, "err_digit", {31'd0, err_digit}, {31'd0, e.ed});
                chk(err_ovf == e.eo, "err_ovf", {31'd0, err_ovf}, {31'd0, e.eo});
                chk(cyc == e.cyc, "latency", cyc, e.cyc);
                chk(busy == 1'b0, "busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called #1 after a posedge: request a conversion, optionally record its expectation
    task automatic issue(input logic [19:0] bcd, input logic [15:0] s,
                         input logic ed, input logic eo, input bit expect_it);
        exp_t e;
        start  = 1'b1;
        bcd_in = bcd;
        if (expect_it) begin
            e.s   = s;
            e.ed  = ed;
            e.eo  = eo;
            e.cyc = cyc + 32'd6;   // start edge is cyc+1, done seen after 5 more edges
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        bcd_in = ~bcd;             // later bcd_in changes must not matter
        chk(busy == 1'b1, "busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk(done == 1'b1, "done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic after_done();
        @(posedge clk); #1;
        chk(done == 1'b0, "done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic run(input logic [19:0] bcd, input logic [15:0] s, input logic ed, input logic eo);
        issue(bcd, s, ed, eo, 1'b1);
        wait_done();
        after_done();
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        bcd_in = 20'h00000;
        repeat (2) @(posedge clk);
        #1;
        chk(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
        chk(done == 1'b0, "rst_done", {31'd0, done}, 32'd0);
        chk(S == 16'h0000, "rst_S", {16'd0, S}, 32'd0);
        chk({err_digit, err_ovf} == 2'b00, "rst_flags", {30'd0, err_digit, err_ovf}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // First conversion with busy tracked cycle by cycle
        issue(20'h65535, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk(busy == 1'b1 && done == 1'b0, "busy_window", {30'd0, busy, done}, 32'd2);
        end
        @(posedge clk); #1;
        chk(done == 1'b1, "done_after_5", {31'd0, done}, 32'd1);
        after_done();

        run(20'h00000, 16'h0000, 1'b0, 1'b0);
        run(20'h01234, 16'h04D2, 1'b0, 1'b0);
        run(20'h65536, 16'hFFFF, 1'b0, 1'b1);
        run(20'h99999, 16'hFFFF, 1'b0, 1'b1);
        run(20'h00042, 16'h002A, 1'b0, 1'b0);
        run(20'h12A34, 16'h2F02, 1'b1, 1'b0);
        run(20'h0000B, 16'h0000, 1'b1, 1'b0);
        run(20'hF0009, 16'h0009, 1'b1, 1'b0);

        // start pulsed mid-conversion with another word is ignored
        issue(20'h00321, 16'h0141, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start  = 1'b1;
        bcd_in = 20'h00777;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done();

        // start in the done cycle is accepted back-to-back
        issue(20'h00007, 16'h0007, 1'b0, 1'b0, 1'b1);
        chk(done == 1'b0, "b2b_done_cleared", {31'd0, done}, 32'd0);
        chk(S == 16'h0141, "b2b_S_held", {16'd0, S}, 32'h141);
        wait_done();
        after_done();

        // Reset applied at the third conversion edge aborts without a done pulse
        issue(20'h54321, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk(busy == 1'b0, "abort_busy", {31'd0, busy}, 32'd0);
        chk(done == 1'b0, "abort_done", {31'd0, done}, 32'd0);
        chk(S == 16'h0000, "abort_S", {16'd0, S}, 32'd0);
        chk({err_digit, err_ovf} == 2'b00, "abort_flags", {30'd0, err_digit, err_ovf}, 32'd0);
        repeat (8) @(posedge clk);
        #1;

        run(20'h00100, 16'h0064, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
Sequential BCD-to-binary converter. It is the inverse of the existing 16-bit binary-to-BCD path. A DIGITS-digit packed BCD word is accepted on a start pulse and converted one digit per clock using acc = acc*10 + digit. The result is presented with a one-cycle done pulse. It sits between keypad/decimal entry logic and the binary datapath (adders, multiplier, counters), with sticky error flags for invalid digits and range overflow.

Parameters:
DIGITS, 5, number of BCD digits in bcd_in
OUT_WIDTH, 16, width of binary result S; max representable value is 2^OUT_WIDTH-1

Ports:
clk  input  1  system clock; all state changes on posedge clk
reset  input  1  synchronous active-low reset, sampled on posedge clk
start  input  1  request conversion of bcd_in; accepted only when busy=0
bcd_in  input  4*DIGITS  packed BCD; most-significant digit in bits [4*DIGITS-1:4*DIGITS-4], least-significant digit in [3:0]
busy  output  1  conversion in progress
done  output  1  one-cycle pulse: S and error flags valid
S  output  OUT_WIDTH  binary result, held until the next completed conversion
err_digit  output  1  sticky: at least one nibble of the latched word was >9
err_ovf  output  1  sticky: decimal value exceeded 2^OUT_WIDTH-1; S saturated

Behaviour:
- Reset (reset=0 at posedge clk): state=IDLE, busy=0, done=0, S=0, err_digit=0, err_ovf=0, internal accumulator, digit counter and shift register cleared. Reset has priority over all other inputs. Reset mid-conversion aborts it; no done pulse is produced.
- States: IDLE, CONV.
- IDLE:
  - done is forced to 0 on every edge in which no conversion completes.
  - If start=1 at edge E0: latch bcd_in into the shift register, set acc=0, cnt=0, clear err_digit and err_ovf, set busy=1, go to CONV.
  - start=0: remain in IDLE; S and the flags hold.
- CONV, one digit per edge (E1..E_DIGITS):
  - digit = top nibble of the shift register.
  - If digit>9: set err_digit and use 0 in place of the digit.
  - next = acc*10 + digit, computed at OUT_WIDTH+4 bits.
  - If next > 2^OUT_WIDTH-1: set err_ovf and clamp acc to 2^OUT_WIDTH-1. Otherwise acc=next. Once clamped, acc stays saturated.
  - Shift register shifts left 4 bits; cnt increments.
- Completion at edge E_DIGITS (the edge that processes the last digit):
  - S <= final acc (including that digit).
  - done <= 1, busy <= 0, state=IDLE.
  - err flags reflect the full word.
- Latency: done is high in the cycle after edge E_DIGITS, i.e. DIGITS cycles after the start edge (5 for defaults). It is high for exactly one cycle.
- Back-to-back: start=1 while done=1 (state IDLE) is accepted. The new conversion clears done and the flags at that edge; S holds its old value until the new completion.
- start while busy=1 is ignored. bcd_in changes after E0 do not affect the conversion in progress.
- Flags and S are only meaningful when done=1 or after it, until the next accepted start.
- Arithmetic: unsigned. acc*10 is implemented as (acc<<3)+(acc<<1). No internal wrap-around is permitted; overflow is always caught by the clamp.

Test Plan:
- Reset, then start with bcd_in=20'h65535 -> busy=1 for 5 cycles; done pulses 5 cycles after the start edge; S=16'hFFFF, err_digit=0, err_ovf=0; done low on the next cycle.
- bcd_in=20'h00000 -> S=0. Then bcd_in=20'h01234 -> S=16'h04D2. Both with no flags.
- Overflow: bcd_in=20'h65536 -> S=16'hFFFF, err_ovf=1. bcd_in=20'h99999 -> S=16'hFFFF, err_ovf=1. A following conversion of 20'h00042 -> S=16'h002A, err_ovf=0.
- Invalid digit: bcd_in=20'h12A34 -> err_digit=1, S=16'h2F02 (12034), err_ovf=0.
- Handshake:
  - Pulse start during CONV with a different bcd_in -> ignored; result matches the first word.
  - start asserted in the done cycle with 20'h00007 -> accepted; second done 5 cycles later with S=7.
  - bcd_in changed after the start edge -> no effect.
- Reset mid-conversion: assert reset=0 at the 3rd CONV edge -> next cycle busy=0, done=0, S=0, flags=0; no done pulse follows. A subsequent start converts normally.
